// File: rtl/voice_allocator_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : voice_allocator_pkg
//  Purpose  : Shared definitions for the 4-voice polyphony allocator.
//             Event type codes, voice count, data width and FSM state encoding.
//  Revision : 1.0  initial release
// ============================================================================
package voice_allocator_pkg;

  localparam int W      = 7;  // MIDI data byte width
  localparam int NVOICE = 4;  // fixed: LRU rank is 2 bits

  localparam logic [1:0] EVT_OFF    = 2'b00;
  localparam logic [1:0] EVT_ON     = 2'b01;
  localparam logic [1:0] EVT_ALLOFF = 2'b10;
  localparam logic [1:0] EVT_IGN    = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCAN   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/voice_allocator_if.sv
`default_nettype none
// ============================================================================
//  Module   : voice_allocator_if
//  Purpose  : Note-event valid/ready channel into the voice allocator.
//  Signals  : evt_valid  event present (master)
//             evt_ready  allocator can accept (slave)
//             evt_type   00 off, 01 on, 10 all-off, 11 ignored (master)
//             evt_note   note number (master)
//             evt_vel    velocity (master)
//  Revision : 1.0  initial release
// ============================================================================
interface voice_allocator_if #(
  parameter int W = 7
);
  logic         evt_valid;
  logic         evt_ready;
  logic [1:0]   evt_type;
  logic [W-1:0] evt_note;
  logic [W-1:0] evt_vel;

  modport master (output evt_valid, evt_type, evt_note, evt_vel, input evt_ready);
  modport slave  (input evt_valid, evt_type, evt_note, evt_vel, output evt_ready);
endinterface
`default_nettype wire

// File: rtl/voice_allocator_lru_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : lru_tracker
//  Purpose  : Least-recently-assigned ranking for 4 voices. Rank 3 = oldest.
//  Ports    : clk        system clock
//             rst        asynchronous active-high reset (ranks 3,2,1,0)
//             touch      strobe: make touch_idx the newest voice (already CE-qualified)
//             touch_idx  voice being assigned
//             oldest     index of the voice holding rank 3
//  Revision : 1.0  initial release
// ============================================================================
module lru_tracker (
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic       touch,
  input  wire logic [1:0] touch_idx,
  output logic      [1:0] oldest
);

  logic [1:0] rank [4];

  // Move-to-front: only voices younger than the touched one age by one,
  // so the four ranks stay a permutation of 0..3.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) rank[i] <= 2'(3 - i);
    end else if (touch) begin
      for (int i = 0; i < 4; i++) begin
        if (2'(i) == touch_idx)
          rank[i] <= 2'd0;
        else if (rank[i] < rank[touch_idx])
          rank[i] <= rank[i] + 2'd1;
      end
    end
  end

  always_comb begin
    oldest = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (rank[i] == 2'd3) oldest = 2'(i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/voice_allocator.sv
`default_nettype none
// ============================================================================
//  Module   : voice_allocator
//  Purpose  : Polyphony scheduler for the 4-voice NCO bank. Accepts note
//             events, scans the voices one per CE cycle, then commits the
//             result (retrigger > free voice > steal oldest) in one edge.
//  Ports    : clk, rst       clock, asynchronous active-high reset
//             ce             clock enable for FSM, handshake and registers
//             evt            event channel (slave modport)
//             note_num_0..3  per-voice note number (registered)
//             note_vel_0..3  per-voice velocity (registered, 0 = silent)
//             voice_busy     bit n set while voice n holds a sounding note
//  Revision : 1.0  initial release
// ============================================================================
module voice_allocator
  import voice_allocator_pkg::*;
#(
  parameter int W      = voice_allocator_pkg::W,
  parameter int NVOICE = voice_allocator_pkg::NVOICE
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        ce,
  voice_allocator_if.slave evt,
  output logic [W-1:0]     note_num_0,
  output logic [W-1:0]     note_num_1,
  output logic [W-1:0]     note_num_2,
  output logic [W-1:0]     note_num_3,
  output logic [W-1:0]     note_vel_0,
  output logic [W-1:0]     note_vel_1,
  output logic [W-1:0]     note_vel_2,
  output logic [W-1:0]     note_vel_3,
  output logic [NVOICE-1:0] voice_busy
);

  state_t       state, state_nxt;
  logic [1:0]   idx;
  logic [1:0]   lat_type;
  logic [W-1:0] lat_note, lat_vel;
  logic         match_found, free_found;
  logic [1:0]   match_idx, free_idx;
  logic [W-1:0] num_r [4];
  logic [W-1:0] vel_r [4];
  logic [3:0]   busy_r;
  logic [1:0]   oldest, target;
  logic         xfer, touch;

  assign xfer   = evt.evt_valid & evt.evt_ready & ce;
  assign target = match_found ? match_idx : (free_found ? free_idx : oldest);
  assign touch  = ce && (state == S_COMMIT) && (lat_type == EVT_ON);

  lru_tracker u_lru (
    .clk       (clk),
    .rst       (rst),
    .touch     (touch),
    .touch_idx (target),
    .oldest    (oldest)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     state <= S_IDLE;
    else if (ce) state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    evt.evt_ready = 1'b0;
    case (state)
      S_IDLE: begin
        evt.evt_ready = 1'b1;
        if (evt.evt_valid) begin
          case (evt.evt_type)
            EVT_ALLOFF: state_nxt = S_COMMIT;
            EVT_IGN:    state_nxt = S_IDLE;
            default:    state_nxt = S_SCAN;
          endcase
        end
      end
      S_SCAN:   if (idx == 2'd3) state_nxt = S_COMMIT;
      S_COMMIT: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx         <= 2'd0;
      lat_type    <= EVT_OFF;
      lat_note    <= '0;
      lat_vel     <= '0;
      match_found <= 1'b0;
      free_found  <= 1'b0;
      match_idx   <= 2'd0;
      free_idx    <= 2'd0;
      busy_r      <= 4'd0;
      for (int i = 0; i < 4; i++) begin
        num_r[i] <= '0;
        vel_r[i] <= '0;
      end
    end else if (ce) begin
      case (state)
        S_IDLE: begin
          if (xfer) begin
            // A zero-velocity note-on is folded into a note-off here so the
            // commit stage only ever sees three event kinds.
            lat_type    <= (evt.evt_type == EVT_ON && evt.evt_vel == '0) ? EVT_OFF : evt.evt_type;
            lat_note    <= evt.evt_note;
            lat_vel     <= evt.evt_vel;
            idx         <= 2'd0;
            match_found <= 1'b0;
            free_found  <= 1'b0;
            match_idx   <= 2'd0;
            free_idx    <= 2'd0;
          end
        end
        S_SCAN: begin
          // Lowest index wins: later hits are ignored once a flag is set.
          if (busy_r[idx] && num_r[idx] == lat_note && !match_found) begin
            match_found <= 1'b1;
            match_idx   <= idx;
          end
          if (!busy_r[idx] && !free_found) begin
            free_found <= 1'b1;
            free_idx   <= idx;
          end
          idx <= idx + 2'd1;
        end
        S_COMMIT: begin
          case (lat_type)
            EVT_ON: begin
              num_r[target]  <= lat_note;
              vel_r[target]  <= lat_vel;
              busy_r[target] <= 1'b1;
            end
            EVT_OFF: begin
              // Pitch is held so the NCO does not glitch during release.
              if (match_found) begin
                vel_r[match_idx]  <= '0;
                busy_r[match_idx] <= 1'b0;
              end
            end
            EVT_ALLOFF: begin
              busy_r <= 4'd0;
              for (int i = 0; i < 4; i++) vel_r[i] <= '0;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign note_num_0 = num_r[0];
  assign note_num_1 = num_r[1];
  assign note_num_2 = num_r[2];
  assign note_num_3 = num_r[3];
  assign note_vel_0 = vel_r[0];
  assign note_vel_1 = vel_r[1];
  assign note_vel_2 = vel_r[2];
  assign note_vel_3 = vel_r[3];
  assign voice_busy = busy_r;

endmodule
`default_nettype wire

// File: tb/tb_voice_allocator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_voice_allocator
//  Purpose  : Self-checking bench for voice_allocator. Stimulus updates a
//             queue-based voice/LRU model and pushes the expected output
//             snapshot; a monitor pops and compares on each event completion.
//  Revision : 1.0  initial release
// ============================================================================
module tb_voice_allocator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce  = 1'b0;

  voice_allocator_if #(.W(7)) evt_if ();

  logic [6:0] nn0, nn1, nn2, nn3, nv0, nv1, nv2, nv3;
  logic [3:0] busy;

  voice_allocator #(.W(7), .NVOICE(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .evt        (evt_if),
    .note_num_0 (nn0),
    .note_num_1 (nn1),
    .note_num_2 (nn2),
    .note_num_3 (nn3),
    .note_vel_0 (nv0),
    .note_vel_1 (nv1),
    .note_vel_2 (nv2),
    .note_vel_3 (nv3),
    .voice_busy (busy)
  );

  always #5 clk = ~clk;

  wire [27:0] act_num = {nn3, nn2, nn1, nn0};
  wire [27:0] act_vel = {nv3, nv2, nv1, nv0};

  typedef struct packed {
    logic [27:0] num;
    logic [27:0] vel;
    logic [3:0]  busy;
    logic [3:0]  lat;
  } exp_t;

  exp_t sb[$];
  exp_t cur_exp;
  int   checks   = 0;
  int   failures = 0;
  int   m_num[4];
  int   m_vel[4];
  bit   m_busy[4];
  int   order[$];   // newest first; order[3] is the steal victim
  bit   mon_en  = 1'b0;
  bit   in_evt  = 1'b0;
  int   ce_mode = 0;
  int   cyc     = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endfunction

  function automatic exp_t snap(input int lat);
    exp_t e;
    e = '0;
    for (int i = 0; i < 4; i++) begin
      e.num[i*7 +: 7] = 7'(m_num[i]);
      e.vel[i*7 +: 7] = 7'(m_vel[i]);
      e.busy[i]       = m_busy[i];
    end
    e.lat = 4'(lat);
    return e;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_num[i] = 0; m_vel[i] = 0; m_busy[i] = 1'b0;
    end
    order = {3, 2, 1, 0};
  endfunction

  function automatic void lru_touch(input int v);
    for (int i = 0; i < order.size(); i++) begin
      if (order[i] == v) begin
        order.delete(i);
        break;
      end
    end
    order.push_front(v);
  endfunction

  function automatic void model_event(input int t, input int note, input int vel);
    int tt;
    int tgt;
    tt  = t;
    tgt = -1;
    if (tt == 3) return;
    if (tt == 1 && vel == 0) tt = 0;
    for (int v = 0; v < 4; v++)
      if (tgt < 0 && m_busy[v] && m_num[v] == note) tgt = v;
    if (tt == 1) begin
      for (int v = 0; v < 4; v++)
        if (tgt < 0 && !m_busy[v]) tgt = v;
      if (tgt < 0) tgt = order[3];
      m_num[tgt] = note; m_vel[tgt] = vel; m_busy[tgt] = 1'b1;
      lru_touch(tgt);
    end else if (tt == 0) begin
      if (tgt >= 0) begin
        m_vel[tgt] = 0; m_busy[tgt] = 1'b0;
      end
    end else begin
      for (int v = 0; v < 4; v++) begin
        m_vel[v] = 0; m_busy[v] = 1'b0;
      end
    end
    sb.push_back(snap(tt == 2 ? 1 : 5));
  endfunction

  task automatic drive_ce();
    cyc++;
    case (ce_mode)
      0:       ce = 1'b1;
      1:       ce = (cyc % 3 == 0);
      default: ce = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  task automatic step();
    drive_ce();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int t, input int note, input int vel);
    bit done;
    bit r;
    done = 1'b0;
    evt_if.evt_valid = 1'b1;
    evt_if.evt_type  = 2'(t);
    evt_if.evt_note  = 7'(note);
    evt_if.evt_vel   = 7'(vel);
    for (int k = 0; k < 400 && !done; k++) begin
      drive_ce();
      r = evt_if.evt_ready & ce;
      @(posedge clk);
      #1;
      if (r) done = 1'b1;
    end
    evt_if.evt_valid = 1'b0;
    evt_if.evt_type  = 2'($urandom_range(0, 3));
    evt_if.evt_note  = 7'($urandom_range(0, 127));
    evt_if.evt_vel   = 7'($urandom_range(0, 127));
    if (!done) begin
      checks++; failures++;
      $display("FAIL send_timeout actual=no_transfer required=transfer");
    end else begin
      model_event(t, note, vel);
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((sb.size() != 0 || in_evt) && k < 2000) begin
      step();
      k++;
    end
    if (k >= 2000) begin
      checks++; failures++;
      $display("FAIL drain_timeout actual=%0d pending required=0", sb.size());
    end
  endtask

  // Monitor: a ready low->high transition marks the commit edge of an event.
  initial begin : monitor
    int   cnt;
    bit   prev_ce;
    exp_t e;
    cnt = 0;
    prev_ce = 1'b0;
    forever begin
      @(negedge clk);
      if (!mon_en || rst) begin
        in_evt = 1'b0;
      end else if (in_evt) begin
        if (prev_ce) cnt++;
        if (evt_if.evt_ready) begin
          in_evt = 1'b0;
          if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_commit actual=commit required=none");
          end else begin
            e = sb.pop_front();
            chk("commit_num", 32'(act_num), 32'(e.num));
            chk("commit_vel", 32'(act_vel), 32'(e.vel));
            chk("commit_busy", 32'(busy), 32'(e.busy));
            chk("latency", 32'(cnt), 32'(e.lat));
            cur_exp = e;
          end
        end else begin
          chk("hold_vel", 32'(act_vel), 32'(cur_exp.vel));
          chk("hold_busy", 32'(busy), 32'(cur_exp.busy));
        end
      end else if (!evt_if.evt_ready) begin
        in_evt = 1'b1;
        cnt    = 0;
        chk("hold_num", 32'(act_num), 32'(cur_exp.num));
      end
      prev_ce = ce;
    end
  end

  initial begin : stimulus
    int r;
    evt_if.evt_valid = 1'b0;
    evt_if.evt_type  = 2'b00;
    evt_if.evt_note  = 7'd0;
    evt_if.evt_vel   = 7'd0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_num", 32'(act_num), 32'd0);
    chk("reset_vel", 32'(act_vel), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_ready", 32'(evt_if.evt_ready), 32'd1);
    @(posedge clk);
    #1;

    model_reset();
    cur_exp = snap(0);
    mon_en  = 1'b1;
    ce_mode = 0;
    send(1, 60, 100);
    drain();

    // Reset in the middle of a scan aborts the event.
    mon_en = 1'b0;
    ce = 1'b1;
    evt_if.evt_valid = 1'b1; evt_if.evt_type = 2'b01;
    evt_if.evt_note = 7'd62; evt_if.evt_vel = 7'd90;
    @(posedge clk); #1;
    evt_if.evt_valid = 1'b0;
    @(posedge clk); #1;
    chk("scan_ready_low", 32'(evt_if.evt_ready), 32'd0);
    rst = 1'b1;
    #2;
    chk("abort_num", 32'(act_num), 32'd0);
    chk("abort_vel", 32'(act_vel), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("abort_ready", 32'(evt_if.evt_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    cur_exp = snap(0);
    mon_en  = 1'b1;

    // Fill, steal, release, free-before-steal.
    send(1, 60, 100); send(1, 62, 90); send(1, 64, 80); send(1, 65, 70);
    drain();
    chk("fill_busy", 32'(busy), 32'hf);
    chk("fill_v3_num", 32'(nn3), 32'd65);
    send(1, 67, 127);
    drain();
    chk("steal_v0_num", 32'(nn0), 32'd67);
    chk("steal_v0_vel", 32'(nv0), 32'd127);
    send(1, 69, 60);
    drain();
    chk("steal_v1_num", 32'(nn1), 32'd69);
    send(0, 69, 0);
    drain();
    chk("off_v1_num", 32'(nn1), 32'd69);
    chk("off_v1_vel", 32'(nv1), 32'd0);
    chk("off_busy", 32'(busy), 32'b1101);
    send(1, 64, 0);
    send(1, 65, 10);
    drain();
    chk("retrig_v3_vel", 32'(nv3), 32'd10);
    chk("retrig_busy", 32'(busy), 32'b1001);
    send(1, 70, 50);
    drain();
    chk("free_v1_num", 32'(nn1), 32'd70);
    send(0, 99, 0);
    send(3, 60, 5);
    send(2, 0, 0);
    drain();
    chk("alloff_busy", 32'(busy), 32'd0);
    chk("alloff_vel", 32'(act_vel), 32'd0);

    // CE gated 1-of-3, then random gating with random events.
    ce_mode = 1;
    send(1, 72, 33);
    send(1, 72, 44);
    drain();
    for (int n = 0; n < 160; n++) begin
      ce_mode = (n < 100) ? 2 : 0;
      r = $urandom_range(0, 9);
      send((r < 6) ? 1 : (r < 8) ? 0 : (r == 8) ? 2 : 3,
           60 + $urandom_range(0, 7),
           ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 127));
      if ($urandom_range(0, 3) == 0) step();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
